// File: rtl/cpu_pkg.sv
// Shared RV32I definitions: opcodes, instruction classes, decode FSM states, classifier.
// Build option DECODE_RV32M_EN makes OP with funct7 = 0000001 decode as CLS_MULDIV.
package cpu_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [3:0] {
      CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD, CLS_STORE,
      CLS_OP_IMM, CLS_OP, CLS_MISC_MEM, CLS_SYSTEM, CLS_MULDIV, CLS_ILLEGAL
   } instr_class_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_FULL = 2'd2
   } dec_state_e;

   typedef struct packed {
      logic [31:0]  pc;
      instr_class_e cls;
      logic [4:0]   rd;
      logic [4:0]   rs1;
      logic [4:0]   rs2;
      logic [2:0]   funct3;
      logic [6:0]   funct7;
      logic [31:0]  imm;
      logic         illegal;
   } dec_out_t;

   function automatic instr_class_e classify(input logic [6:0] opcode,
                                             input logic [2:0] funct3,
                                             input logic [6:0] funct7);
      instr_class_e cls;
      cls = CLS_ILLEGAL;
      case (opcode)
         OPC_LUI:      cls = CLS_LUI;
         OPC_AUIPC:    cls = CLS_AUIPC;
         OPC_JAL:      cls = CLS_JAL;
         OPC_JALR:     if (funct3 == 3'b000) cls = CLS_JALR;
         OPC_BRANCH:   if (funct3 != 3'b010 && funct3 != 3'b011) cls = CLS_BRANCH;
         OPC_LOAD:     if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) cls = CLS_LOAD;
         OPC_STORE:    if (funct3 < 3'b011) cls = CLS_STORE;
         OPC_OP_IMM: begin
            // Only the shift forms carry a meaningful funct7 field.
            if (funct3 == 3'b001) begin
               if (funct7 == 7'b0000000) cls = CLS_OP_IMM;
            end else if (funct3 == 3'b101) begin
               if (funct7 == 7'b0000000 || funct7 == 7'b0100000) cls = CLS_OP_IMM;
            end else begin
               cls = CLS_OP_IMM;
            end
         end
         OPC_OP: begin
            if (funct7 == 7'b0000000 ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
               cls = CLS_OP;
`ifdef DECODE_RV32M_EN
            else if (funct7 == 7'b0000001)
               cls = CLS_MULDIV;
`endif
         end
         OPC_MISC_MEM: cls = CLS_MISC_MEM;
         OPC_SYSTEM:   cls = CLS_SYSTEM;
         default:      cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-request and execute-handshake signals of the decode stage.
// master = decode stage, slave = fetch/execute side.
interface decode_if;
   import cpu_pkg::*;

   logic         o_fetch_enable;
   logic [31:0]  o_fetch_pc;
   logic         i_fetch_completed;
   logic [31:0]  i_fetch_instr;
   logic         i_redirect;
   logic [31:0]  i_redirect_pc;
   logic         o_valid;
   logic         i_ready;
   logic [31:0]  o_pc;
   instr_class_e o_class;
   logic [4:0]   o_rd;
   logic [4:0]   o_rs1;
   logic [4:0]   o_rs2;
   logic [2:0]   o_funct3;
   logic [6:0]   o_funct7;
   logic [31:0]  o_imm;
   logic         o_illegal;

   modport master (
      output o_fetch_enable, o_fetch_pc, o_valid, o_pc, o_class, o_rd, o_rs1, o_rs2,
             o_funct3, o_funct7, o_imm, o_illegal,
      input  i_fetch_completed, i_fetch_instr, i_redirect, i_redirect_pc, i_ready
   );

   modport slave (
      input  o_fetch_enable, o_fetch_pc, o_valid, o_pc, o_class, o_rd, o_rs1, o_rs2,
             o_funct3, o_funct7, o_imm, o_illegal,
      output i_fetch_completed, i_fetch_instr, i_redirect, i_redirect_pc, i_ready
   );

endinterface

// File: rtl/decode_imm_gen.sv
// Combinational immediate extraction and sign extension, selected by instruction class.
module imm_gen
   import cpu_pkg::*;
(
   input  logic [31:7]  instr,
   input  instr_class_e cls,
   output logic [31:0]  imm
);

   always_comb begin
      imm = 32'h0;
      case (cls)
         CLS_LOAD, CLS_OP_IMM, CLS_JALR, CLS_MISC_MEM, CLS_SYSTEM:
            imm = {{20{instr[31]}}, instr[31:20]};
         CLS_STORE:
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         CLS_BRANCH:
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         CLS_LUI, CLS_AUIPC:
            imm = {instr[31:12], 12'h000};
         CLS_JAL:
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm = 32'h0;
      endcase
   end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: owns the PC, issues one fetch at a time, hands decoded words to execute.
// Build option DECODE_RV32M_EN (see cpu_pkg) enables the CLS_MULDIV class.
module decode
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic     clk,
   input  logic     reset,
   decode_if.master bus
);

   dec_state_e   state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         discard_q, discard_d;
   logic         fetch_en_q, fetch_en_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic         valid_q, valid_d;
   dec_out_t     out_q, out_d;
   instr_class_e fetch_cls;
   logic [31:0]  fetch_imm;

   assign fetch_cls = classify(bus.i_fetch_instr[6:0], bus.i_fetch_instr[14:12],
                               bus.i_fetch_instr[31:25]);

   imm_gen u_imm_gen (
      .instr (bus.i_fetch_instr[31:7]),
      .cls   (fetch_cls),
      .imm   (fetch_imm)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         discard_q  <= 1'b0;
         fetch_en_q <= 1'b0;
         fetch_pc_q <= RESET_PC;
         valid_q    <= 1'b0;
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         discard_q  <= discard_d;
         fetch_en_q <= fetch_en_d;
         fetch_pc_q <= fetch_pc_d;
         valid_q    <= valid_d;
         out_q      <= out_d;
      end
   end

   // Redirect is evaluated first in every state so it wins over issue, completion and accept.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      discard_d  = discard_q;
      fetch_en_d = 1'b0;
      fetch_pc_d = fetch_pc_q;
      valid_d    = valid_q;
      out_d      = out_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_redirect) begin
               pc_d = bus.i_redirect_pc;
            end else begin
               fetch_en_d = 1'b1;
               fetch_pc_d = pc_q;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.i_redirect) begin
               pc_d = bus.i_redirect_pc;
               if (bus.i_fetch_completed) begin
                  discard_d = 1'b0;
                  state_d   = ST_IDLE;
               end else begin
                  discard_d = 1'b1;
               end
            end else if (bus.i_fetch_completed) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = ST_IDLE;
               end else begin
                  valid_d        = 1'b1;
                  out_d.pc       = pc_q;
                  out_d.cls      = fetch_cls;
                  out_d.rd       = bus.i_fetch_instr[11:7];
                  out_d.rs1      = bus.i_fetch_instr[19:15];
                  out_d.rs2      = bus.i_fetch_instr[24:20];
                  out_d.funct3   = bus.i_fetch_instr[14:12];
                  out_d.funct7   = bus.i_fetch_instr[31:25];
                  out_d.imm      = fetch_imm;
                  out_d.illegal  = (fetch_cls == CLS_ILLEGAL);
                  state_d        = ST_FULL;
               end
            end
         end
         ST_FULL: begin
            if (bus.i_redirect) begin
               valid_d = 1'b0;
               pc_d    = bus.i_redirect_pc;
               state_d = ST_IDLE;
            end else if (valid_q && bus.i_ready) begin
               valid_d = 1'b0;
               pc_d    = pc_q + 32'd4;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.o_fetch_enable = fetch_en_q;
   assign bus.o_fetch_pc     = fetch_pc_q;
   assign bus.o_valid        = valid_q;
   assign bus.o_pc           = out_q.pc;
   assign bus.o_class        = out_q.cls;
   assign bus.o_rd           = out_q.rd;
   assign bus.o_rs1          = out_q.rs1;
   assign bus.o_rs2          = out_q.rs2;
   assign bus.o_funct3       = out_q.funct3;
   assign bus.o_funct7       = out_q.funct7;
   assign bus.o_imm          = out_q.imm;
   assign bus.o_illegal      = out_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios plus randomized traffic against a reference decoder.
module tb_decode;
   import cpu_pkg::*;

   typedef logic [94:0] vec_t;
   typedef struct packed { instr_class_e cls; logic illegal; logic [31:0] imm; } ref_t;

`ifdef DECODE_RV32M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          fails = 0;
   logic [31:0] exp_pc;
   logic [6:0]  op_table [0:10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                    7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

   decode_if dif ();
   decode #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(dif));

   always #5 clk = ~clk;

   // Reference decoder built from the RV32I field layout with plain arithmetic.
   function automatic ref_t ref_decode(input logic [31:0] w);
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [7:0]  br_ok, ld_ok;
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
      ref_t r;
      op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      br_ok = 8'b1111_0011; ld_ok = 8'b0011_0111;
      imm_i = 32'($signed(w) >>> 20);
      imm_s = 32'(($signed(w) >>> 25) << 5) | 32'(w[11:7]);
      imm_b = 32'(($signed(w) >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      imm_u = w & 32'hFFFF_F000;
      imm_j = 32'(($signed(w) >>> 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      r.cls = CLS_ILLEGAL; r.imm = 32'h0;
      case (op)
         7'h37: begin r.cls = CLS_LUI;   r.imm = imm_u; end
         7'h17: begin r.cls = CLS_AUIPC; r.imm = imm_u; end
         7'h6F: begin r.cls = CLS_JAL;   r.imm = imm_j; end
         7'h67: if (f3 == 0) begin r.cls = CLS_JALR; r.imm = imm_i; end
         7'h63: if (br_ok[f3]) begin r.cls = CLS_BRANCH; r.imm = imm_b; end
         7'h03: if (ld_ok[f3]) begin r.cls = CLS_LOAD; r.imm = imm_i; end
         7'h23: if (f3 <= 2) begin r.cls = CLS_STORE; r.imm = imm_s; end
         7'h13: if ((f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 7'h20)) || (f3 != 1 && f3 != 5))
                   begin r.cls = CLS_OP_IMM; r.imm = imm_i; end
         7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) r.cls = CLS_OP;
                else if (f7 == 7'h01 && M_EN) r.cls = CLS_MULDIV;
         7'h0F: begin r.cls = CLS_MISC_MEM; r.imm = imm_i; end
         7'h73: begin r.cls = CLS_SYSTEM;   r.imm = imm_i; end
         default: r.cls = CLS_ILLEGAL;
      endcase
      r.illegal = (r.cls == CLS_ILLEGAL);
      return r;
   endfunction

   function automatic vec_t exp_vec(input logic [31:0] w, input logic [31:0] pc);
      ref_t r;
      r = ref_decode(w);
      return {1'b1, r.illegal, r.cls, pc, r.imm, w[11:7], w[19:15], w[24:20], w[14:12], w[31:25]};
   endfunction

   function automatic vec_t obs_vec();
      return {dif.o_valid, dif.o_illegal, dif.o_class, dif.o_pc, dif.o_imm, dif.o_rd,
              dif.o_rs1, dif.o_rs2, dif.o_funct3, dif.o_funct7};
   endfunction

   function automatic logic [31:0] gen_word();
      logic [31:0] w;
      logic [6:0]  f7s [0:2];
      f7s = '{7'h00, 7'h20, 7'h01};
      w = $urandom();
      if ($urandom_range(0, 3) != 0) begin
         w[6:0] = op_table[$urandom_range(0, 10)];
         if ($urandom_range(0, 1) == 1) w[31:25] = f7s[$urandom_range(0, 2)];
      end
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_issue(output bit seen, output logic [31:0] addr);
      seen = 1'b0;
      addr = 32'h0;
      for (int i = 0; i < 8 && !seen; i++) begin
         step();
         if (dif.o_fetch_enable === 1'b1) begin
            seen = 1'b1;
            addr = dif.o_fetch_pc;
         end
      end
   endtask

   task automatic complete(input logic [31:0] w, input int delay);
      repeat (delay) step();
      dif.i_fetch_completed = 1'b1;
      dif.i_fetch_instr     = w;
      step();
      dif.i_fetch_completed = 1'b0;
      dif.i_fetch_instr     = $urandom();
   endtask

   task automatic accept();
      dif.i_ready = 1'b1;
      step();
      dif.i_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) step();
      checks++; if (obs_vec() !== '0 || dif.o_fetch_enable !== 1'b0 || dif.o_fetch_pc !== 32'h0) begin
         fails++; $display("[TB] FAIL reset_values: got %h fe=%b fpc=%h required all zero", obs_vec(), dif.o_fetch_enable, dif.o_fetch_pc);
      end
      reset = 1'b1;
      step();
      checks++; if (dif.o_fetch_enable !== 1'b1 || dif.o_fetch_pc !== 32'h0) begin
         fails++; $display("[TB] FAIL first_issue: got fe=%b pc=%h required fe=1 pc=0", dif.o_fetch_enable, dif.o_fetch_pc);
      end
      step();
      checks++; if (dif.o_fetch_enable !== 1'b0) begin
         fails++; $display("[TB] FAIL issue_pulse_width: got fe=%b required 0", dif.o_fetch_enable);
      end
      exp_pc = 32'h0;
   endtask

   task automatic test_basic();
      bit seen; logic [31:0] addr;
      complete(32'h0050_0093, 0);
      checks++; if (obs_vec() !== exp_vec(32'h0050_0093, exp_pc)) begin
         fails++; $display("[TB] FAIL basic_decode: got %h required %h", obs_vec(), exp_vec(32'h0050_0093, exp_pc));
      end
      checks++; if (dif.o_class !== CLS_OP_IMM || dif.o_rd !== 5'd1 || dif.o_rs1 !== 5'd0 || dif.o_imm !== 32'd5) begin
         fails++; $display("[TB] FAIL addi_fields: got cls=%0d rd=%0d rs1=%0d imm=%h required 7/1/0/5", dif.o_class, dif.o_rd, dif.o_rs1, dif.o_imm);
      end
      accept();
      checks++; if (dif.o_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL basic_accept: got valid=%b required 0", dif.o_valid);
      end
      exp_pc = exp_pc + 32'd4;
      wait_issue(seen, addr);
      checks++; if (!seen || addr !== exp_pc) begin
         fails++; $display("[TB] FAIL basic_next_pc: got %h seen=%0b required %h", addr, seen, exp_pc);
      end
   endtask

   task automatic test_stall();
      bit seen; logic [31:0] addr, w;
      w = 32'hFFC1_0113;
      complete(w, 2);
      for (int i = 0; i < 5; i++) begin
         checks++; if (obs_vec() !== exp_vec(w, exp_pc) || dif.o_fetch_enable !== 1'b0) begin
            fails++; $display("[TB] FAIL stall_hold: got %h fe=%b required %h fe=0", obs_vec(), dif.o_fetch_enable, exp_vec(w, exp_pc));
         end
         step();
      end
      accept();
      checks++; if (dif.o_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL stall_accept_once: got valid=%b required 0", dif.o_valid);
      end
      exp_pc = exp_pc + 32'd4;
      wait_issue(seen, addr);
      checks++; if (!seen || addr !== exp_pc) begin
         fails++; $display("[TB] FAIL stall_next_pc: got %h seen=%0b required %h", addr, seen, exp_pc);
      end
   endtask

   task automatic test_redirect_wait();
      bit seen; logic [31:0] addr;
      dif.i_redirect = 1'b1; dif.i_redirect_pc = 32'h100;
      step();
      dif.i_redirect = 1'b0;
      complete(32'h0050_0093, 1);
      checks++; if (dif.o_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL redirect_wait_drop: got valid=%b required 0", dif.o_valid);
      end
      exp_pc = 32'h100;
      wait_issue(seen, addr);
      checks++; if (!seen || addr !== exp_pc || dif.o_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL redirect_wait_pc: got %h seen=%0b valid=%b required %h", addr, seen, dif.o_valid, exp_pc);
      end
   endtask

   task automatic test_illegal();
      bit seen; logic [31:0] addr;
      complete(32'h0000_0000, 0);
      checks++; if (dif.o_valid !== 1'b1 || dif.o_illegal !== 1'b1 || dif.o_class !== CLS_ILLEGAL) begin
         fails++; $display("[TB] FAIL illegal_zero: got v=%b ill=%b cls=%0d required 1/1/12", dif.o_valid, dif.o_illegal, dif.o_class);
      end
      accept();
      exp_pc = exp_pc + 32'd4;
      wait_issue(seen, addr);
      checks++; if (!seen || addr !== exp_pc) begin
         fails++; $display("[TB] FAIL illegal_next_pc: got %h seen=%0b required %h", addr, seen, exp_pc);
      end
   endtask

   task automatic test_muldiv_redirect_full();
      bit seen; logic [31:0] addr;
      complete(32'h0220_8033, 1);
      checks++; if (dif.o_illegal !== !M_EN || dif.o_class !== (M_EN ? CLS_MULDIV : CLS_ILLEGAL) || dif.o_rs1 !== 5'd1 || dif.o_rs2 !== 5'd2) begin
         fails++; $display("[TB] FAIL muldiv: got ill=%b cls=%0d rs1=%0d rs2=%0d required M_EN=%0b rs1=1 rs2=2", dif.o_illegal, dif.o_class, dif.o_rs1, dif.o_rs2, M_EN);
      end
      dif.i_redirect = 1'b1; dif.i_redirect_pc = 32'h200; dif.i_ready = 1'b1;
      step();
      dif.i_redirect = 1'b0; dif.i_ready = 1'b0;
      checks++; if (dif.o_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL redirect_full_valid: got %b required 0", dif.o_valid);
      end
      exp_pc = 32'h200;
      wait_issue(seen, addr);
      checks++; if (!seen || addr !== exp_pc) begin
         fails++; $display("[TB] FAIL redirect_full_pc: got %h seen=%0b required %h", addr, seen, exp_pc);
      end
   endtask

   task automatic test_redirect_idle_wrap();
      bit seen; logic [31:0] addr, w;
      complete(32'h1234_5037, 0);
      accept();
      dif.i_redirect = 1'b1; dif.i_redirect_pc = 32'hFFFF_FFFC;
      step();
      dif.i_redirect = 1'b0;
      exp_pc = 32'hFFFF_FFFC;
      wait_issue(seen, addr);
      checks++; if (!seen || addr !== exp_pc) begin
         fails++; $display("[TB] FAIL redirect_idle_pc: got %h seen=%0b required %h", addr, seen, exp_pc);
      end
      w = 32'h8000_006F;
      complete(w, 1);
      checks++; if (obs_vec() !== exp_vec(w, exp_pc)) begin
         fails++; $display("[TB] FAIL jal_at_top: got %h required %h", obs_vec(), exp_vec(w, exp_pc));
      end
      accept();
      exp_pc = 32'h0;
      wait_issue(seen, addr);
      checks++; if (!seen || addr !== exp_pc) begin
         fails++; $display("[TB] FAIL pc_wrap: got %h seen=%0b required %h", addr, seen, exp_pc);
      end
   endtask

   task automatic test_redirect_same_cycle();
      bit seen; logic [31:0] addr;
      dif.i_redirect = 1'b1; dif.i_redirect_pc = 32'h300;
      dif.i_fetch_completed = 1'b1; dif.i_fetch_instr = 32'h0050_0093;
      step();
      dif.i_redirect = 1'b0; dif.i_fetch_completed = 1'b0;
      checks++; if (dif.o_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL same_cycle_drop: got valid=%b required 0", dif.o_valid);
      end
      exp_pc = 32'h300;
      wait_issue(seen, addr);
      checks++; if (!seen || addr !== exp_pc) begin
         fails++; $display("[TB] FAIL same_cycle_pc: got %h seen=%0b required %h", addr, seen, exp_pc);
      end
   endtask

   task automatic test_reset_mid();
      complete(32'h0050_0093, 0);
      reset = 1'b0;
      #1;
      checks++; if (obs_vec() !== '0 || dif.o_fetch_pc !== 32'h0) begin
         fails++; $display("[TB] FAIL async_reset: got %h fpc=%h required zero", obs_vec(), dif.o_fetch_pc);
      end
      step();
      reset = 1'b1;
      dif.i_fetch_completed = 1'b1; dif.i_fetch_instr = 32'h0050_0093;
      step();
      dif.i_fetch_completed = 1'b0;
      checks++; if (dif.o_fetch_enable !== 1'b1 || dif.o_fetch_pc !== 32'h0 || dif.o_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL late_completion: got fe=%b fpc=%h valid=%b required 1/0/0", dif.o_fetch_enable, dif.o_fetch_pc, dif.o_valid);
      end
      exp_pc = 32'h0;
   endtask

   task automatic test_random();
      bit seen; logic [31:0] addr, w, tgt;
      int r;
      for (int n = 0; n < 40; n++) begin
         w = gen_word(); r = $urandom_range(0, 9); tgt = $urandom();
         if (r == 0) begin
            dif.i_redirect = 1'b1; dif.i_redirect_pc = tgt;
            if ($urandom_range(0, 1) == 1) begin
               dif.i_fetch_completed = 1'b1; dif.i_fetch_instr = w;
               step();
               dif.i_redirect = 1'b0; dif.i_fetch_completed = 1'b0;
            end else begin
               step();
               dif.i_redirect = 1'b0;
               complete(w, $urandom_range(0, 2));
            end
            checks++; if (dif.o_valid !== 1'b0) begin
               fails++; $display("[TB] FAIL rand_drop[%0d]: got valid=%b required 0", n, dif.o_valid);
            end
            exp_pc = tgt;
         end else begin
            complete(w, $urandom_range(0, 2));
            checks++; if (obs_vec() !== exp_vec(w, exp_pc)) begin
               fails++; $display("[TB] FAIL rand_decode[%0d] w=%h: got %h required %h", n, w, obs_vec(), exp_vec(w, exp_pc));
            end
            repeat ($urandom_range(0, 3)) step();
            checks++; if (obs_vec() !== exp_vec(w, exp_pc) || dif.o_fetch_enable !== 1'b0) begin
               fails++; $display("[TB] FAIL rand_hold[%0d]: got %h fe=%b required %h", n, obs_vec(), dif.o_fetch_enable, exp_vec(w, exp_pc));
            end
            if (r == 1) begin
               dif.i_redirect = 1'b1; dif.i_redirect_pc = tgt; dif.i_ready = $urandom_range(0, 1);
               step();
               dif.i_redirect = 1'b0; dif.i_ready = 1'b0;
               exp_pc = tgt;
            end else begin
               accept();
               exp_pc = exp_pc + 32'd4;
            end
            checks++; if (dif.o_valid !== 1'b0) begin
               fails++; $display("[TB] FAIL rand_release[%0d]: got valid=%b required 0", n, dif.o_valid);
            end
            if (r == 2) begin
               dif.i_redirect = 1'b1; dif.i_redirect_pc = tgt;
               step();
               dif.i_redirect = 1'b0;
               exp_pc = tgt;
            end
         end
         wait_issue(seen, addr);
         checks++; if (!seen || addr !== exp_pc) begin
            fails++; $display("[TB] FAIL rand_next_pc[%0d]: got %h seen=%0b required %h", n, addr, seen, exp_pc);
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      dif.i_fetch_completed = 1'b0;
      dif.i_fetch_instr     = 32'h0;
      dif.i_redirect        = 1'b0;
      dif.i_redirect_pc     = 32'h0;
      dif.i_ready           = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_redirect_wait();
      test_illegal();
      test_muldiv_redirect_full();
      test_redirect_idle_wrap();
      test_redirect_same_cycle();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
